// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one ALUControl + ALU datapath between two clients. Requests are
//   granted round-robin, issued to the ALU for exactly one cycle (EXEC), and
//   the registered result/zero flag is returned with a one-cycle strobe to
//   the client that issued it (RESP). A new request may be accepted in the
//   same cycle as a response, giving one operation every two cycles.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake for client N (0,1)
//   reqN_aluop, reqN_funct         ALUOp / function field for client N
//   reqN_a, reqN_b                 operands for client N
//   alu_op, alu_funct              to ALUControl (zero outside EXEC)
//   alu_a, alu_b                   to ALU operands (hold last latched values)
//   alu_result, alu_zero           combinational ALU outputs
//   rsp0_valid, rsp1_valid         one-cycle response strobes
//   rsp_data, rsp_zero             registered result and zero flag
//   busy                           high in EXEC or RESP
//   last_grant                     index of most recently accepted client
module alu_share_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [2:0]            req0_aluop,
   input  logic [5:0]            req0_funct,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [2:0]            req1_aluop,
   input  logic [5:0]            req1_funct,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic [2:0]            alu_op,
   output logic [5:0]            alu_funct,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  rsp0_valid,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_zero,
   output logic                  busy,
   output logic                  last_grant
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic [2:0]              op_q;
   logic [5:0]              funct_q;
   logic [DATA_WIDTH-1:0]   a_q, b_q;
   logic [DATA_WIDTH-1:0]   rsp_data_q;
   logic                    rsp_zero_q;

   logic                    accept;
   logic                    winner;

   // Next-state, arbitration and outputs
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      accept       = 1'b0;
      winner       = 1'b0;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      alu_op       = 3'b000;
      alu_funct    = 6'b000000;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;

      // On a tie the client that did not win last time gets the grant.
      if (req0_valid && req1_valid) begin
         winner = ~last_grant_q;
      end else begin
         winner = req1_valid;
      end

      // Reset masks the readies so nothing looks accepted in a reset cycle.
      accept = (state_q != S_EXEC) && !reset && (req0_valid || req1_valid);
      req0_ready = accept && !winner;
      req1_ready = accept && winner;

      if (accept) begin
         last_grant_d = winner;
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_EXEC;
         end
         S_EXEC: begin
            alu_op    = op_q;
            alu_funct = funct_q;
            state_d   = S_RESP;
         end
         S_RESP: begin
            // last_grant_q still names the owner of the op being returned;
            // it only moves at the edge that accepts the next op.
            rsp0_valid = !last_grant_q;
            rsp1_valid = last_grant_q;
            state_d    = accept ? S_EXEC : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         op_q         <= '0;
         funct_q      <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         if (accept) begin
            op_q    <= winner ? req1_aluop : req0_aluop;
            funct_q <= winner ? req1_funct : req0_funct;
            a_q     <= winner ? req1_a     : req0_a;
            b_q     <= winner ? req1_b     : req0_b;
         end
         if (state_q == S_EXEC) begin
            rsp_data_q <= alu_result;
            rsp_zero_q <= alu_zero;
         end
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;
   assign busy       = (state_q != S_IDLE);
   assign last_grant = last_grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready;
   logic [2:0]    req0_aluop;
   logic [5:0]    req0_funct;
   logic [DW-1:0] req0_a, req0_b;
   logic          req1_valid, req1_ready;
   logic [2:0]    req1_aluop;
   logic [5:0]    req1_funct;
   logic [DW-1:0] req1_a, req1_b;
   logic [2:0]    alu_op;
   logic [5:0]    alu_funct;
   logic [DW-1:0] alu_a, alu_b;
   logic [DW-1:0] alu_result;
   logic          alu_zero;
   logic          rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_zero;
   logic          busy;
   logic          last_grant;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
      .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
      .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero),
      .busy(busy), .last_grant(last_grant)
   );

   // Reference ALUControl + ALU
   always_comb begin
      alu_result = '0;
      case (alu_op)
         3'b000: alu_result = alu_a + alu_b;
         3'b001: alu_result = alu_a | alu_b;
         3'b111: begin
            case (alu_funct)
               6'b100000: alu_result = alu_a + alu_b;
               6'b100010: alu_result = alu_a - alu_b;
               6'b100100: alu_result = alu_a & alu_b;
               6'b100101: alu_result = alu_a | alu_b;
               6'b101010: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
               default:   alu_result = '0;
            endcase
         end
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic start_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req0_valid = 1'b0; req0_aluop = 3'd0; req0_funct = 6'd0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_aluop = 3'd0; req1_funct = 6'd0; req1_a = '0; req1_b = '0;
   endtask

   // Leaves the DUT in IDLE, reset just released, in the current cycle.
   task automatic do_reset;
      start_cycle;
      reset = 1'b1;
      idle_inputs;
      start_cycle;
      start_cycle;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs;
      req0_valid = 1'b1; req0_aluop = 3'b111; req0_funct = 6'b100000; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1'b1; req1_aluop = 3'b001; req1_funct = 6'b000000; req1_a = 32'd2; req1_b = 32'd2;
      for (int c = 0; c < 2; c++) begin
         start_cycle;
         @(negedge clk);
         if (req0_ready !== 1'b0) begin $display("FAIL reset_ready0 c=%0d got=%b exp=0", c, req0_ready); n_err++; end
         n_cmp++;
         if (req1_ready !== 1'b0) begin $display("FAIL reset_ready1 c=%0d got=%b exp=0", c, req1_ready); n_err++; end
         n_cmp++;
         if ({rsp0_valid, rsp1_valid} !== 2'b00) begin $display("FAIL reset_rsp c=%0d got=%b exp=00", c, {rsp0_valid, rsp1_valid}); n_err++; end
         n_cmp++;
         if (busy !== 1'b0) begin $display("FAIL reset_busy c=%0d got=%b exp=0", c, busy); n_err++; end
         n_cmp++;
         if (alu_op !== 3'b000) begin $display("FAIL reset_alu_op c=%0d got=%b exp=000", c, alu_op); n_err++; end
         n_cmp++;
         if (last_grant !== 1'b1) begin $display("FAIL reset_last_grant c=%0d got=%b exp=1", c, last_grant); n_err++; end
         n_cmp++;
         if (rsp_data !== 32'd0) begin $display("FAIL reset_rsp_data c=%0d got=%0h exp=0", c, rsp_data); n_err++; end
         n_cmp++;
      end
      start_cycle;
      reset = 1'b0;
      @(negedge clk);
      if (req0_ready !== 1'b1) begin $display("FAIL reset_release_ready0 got=%b exp=1", req0_ready); n_err++; end
      n_cmp++;
      if (req1_ready !== 1'b0) begin $display("FAIL reset_release_ready1 got=%b exp=0", req1_ready); n_err++; end
      n_cmp++;
      $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_err);
      do_reset;
   endtask

   task automatic test_single_add;
      req0_valid = 1'b1; req0_aluop = 3'b111; req0_funct = 6'b100000; req0_a = 32'd5; req0_b = 32'd7;
      @(negedge clk);
      if (req0_ready !== 1'b1) begin $display("FAIL add_ready0 got=%b exp=1", req0_ready); n_err++; end
      n_cmp++;
      start_cycle;
      req0_valid = 1'b0;
      @(negedge clk);
      if (alu_op !== 3'b111) begin $display("FAIL add_alu_op got=%b exp=111", alu_op); n_err++; end
      n_cmp++;
      if (alu_funct !== 6'b100000) begin $display("FAIL add_alu_funct got=%b exp=100000", alu_funct); n_err++; end
      n_cmp++;
      if (alu_a !== 32'd5 || alu_b !== 32'd7) begin $display("FAIL add_operands got=%0d,%0d exp=5,7", alu_a, alu_b); n_err++; end
      n_cmp++;
      if (busy !== 1'b1 || req0_ready !== 1'b0) begin $display("FAIL add_exec_busy got busy=%b rdy=%b exp busy=1 rdy=0", busy, req0_ready); n_err++; end
      n_cmp++;
      start_cycle;
      @(negedge clk);
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin $display("FAIL add_rsp_valid got=%b%b exp=10", rsp0_valid, rsp1_valid); n_err++; end
      n_cmp++;
      if (rsp_data !== 32'd12) begin $display("FAIL add_rsp_data got=%0d exp=12", rsp_data); n_err++; end
      n_cmp++;
      if (rsp_zero !== 1'b0) begin $display("FAIL add_rsp_zero got=%b exp=0", rsp_zero); n_err++; end
      n_cmp++;
      if (alu_op !== 3'b000 || last_grant !== 1'b0) begin $display("FAIL add_resp_state got op=%b lg=%b exp op=000 lg=0", alu_op, last_grant); n_err++; end
      n_cmp++;
      start_cycle;
      @(negedge clk);
      if (rsp0_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'd12) begin
         $display("FAIL add_after got rsp0=%b busy=%b data=%0d exp 0,0,12", rsp0_valid, busy, rsp_data); n_err++;
      end
      n_cmp++;
      $display("test_single_add done: compared=%0d mismatched=%0d", n_cmp, n_err);
      do_reset;
   endtask

   task automatic test_contention;
      logic [8:0] exp_r0, exp_r1, exp_v0, exp_v1;
      exp_r0 = 9'b000010001;   // bit c = cycle c
      exp_r1 = 9'b001000100;
      exp_v0 = 9'b001000100;
      exp_v1 = 9'b100010000;
      req0_aluop = 3'b111; req0_funct = 6'b100000; req0_a = 32'd10; req0_b = 32'd3;  // add -> 13
      req1_aluop = 3'b111; req1_funct = 6'b100010; req1_a = 32'd10; req1_b = 32'd3;  // sub -> 7
      for (int c = 0; c < 9; c++) begin
         if (c > 0) start_cycle;
         req0_valid = (c < 8);
         req1_valid = (c < 8);
         @(negedge clk);
         if (req0_ready !== exp_r0[c]) begin $display("FAIL cont_ready0 c=%0d got=%b exp=%b", c, req0_ready, exp_r0[c]); n_err++; end
         n_cmp++;
         if (req1_ready !== exp_r1[c]) begin $display("FAIL cont_ready1 c=%0d got=%b exp=%b", c, req1_ready, exp_r1[c]); n_err++; end
         n_cmp++;
         if (rsp0_valid !== exp_v0[c]) begin $display("FAIL cont_rsp0 c=%0d got=%b exp=%b", c, rsp0_valid, exp_v0[c]); n_err++; end
         n_cmp++;
         if (rsp1_valid !== exp_v1[c]) begin $display("FAIL cont_rsp1 c=%0d got=%b exp=%b", c, rsp1_valid, exp_v1[c]); n_err++; end
         n_cmp++;
         if (exp_v0[c]) begin
            if (rsp_data !== 32'd13) begin $display("FAIL cont_data0 c=%0d got=%0d exp=13", c, rsp_data); n_err++; end
            n_cmp++;
         end
         if (exp_v1[c]) begin
            if (rsp_data !== 32'd7) begin $display("FAIL cont_data1 c=%0d got=%0d exp=7", c, rsp_data); n_err++; end
            n_cmp++;
         end
      end
      $display("test_contention done: compared=%0d mismatched=%0d", n_cmp, n_err);
      do_reset;
   endtask

   task automatic test_back_to_back;
      int accepts = 0;
      logic e_rdy, e_rsp;
      req1_aluop = 3'b001; req1_funct = 6'b000000; req1_a = 32'h0F; req1_b = 32'hF0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) start_cycle;
         req1_valid = (c < 7);
         e_rdy = (c % 2 == 0) && (c <= 6);
         e_rsp = (c % 2 == 0) && (c >= 2);
         @(negedge clk);
         if (req1_ready) accepts++;
         if (req1_ready !== e_rdy) begin $display("FAIL b2b_ready1 c=%0d got=%b exp=%b", c, req1_ready, e_rdy); n_err++; end
         n_cmp++;
         if (rsp1_valid !== e_rsp) begin $display("FAIL b2b_rsp1 c=%0d got=%b exp=%b", c, rsp1_valid, e_rsp); n_err++; end
         n_cmp++;
         if (rsp0_valid !== 1'b0) begin $display("FAIL b2b_rsp0 c=%0d got=%b exp=0", c, rsp0_valid); n_err++; end
         n_cmp++;
         if (e_rsp) begin
            if (rsp_data !== 32'hFF) begin $display("FAIL b2b_data c=%0d got=%0h exp=ff", c, rsp_data); n_err++; end
            n_cmp++;
         end
      end
      if (accepts != 4) begin $display("FAIL b2b_accepts got=%0d exp=4", accepts); n_err++; end
      n_cmp++;
      $display("test_back_to_back done: compared=%0d mismatched=%0d", n_cmp, n_err);
      do_reset;
   endtask

   task automatic test_zero_flag;
      req0_valid = 1'b1; req0_aluop = 3'b111; req0_funct = 6'b100100; req0_a = 32'hF0; req0_b = 32'h0F;
      @(negedge clk);
      if (req0_ready !== 1'b1) begin $display("FAIL zero_ready0 got=%b exp=1", req0_ready); n_err++; end
      n_cmp++;
      start_cycle;
      req0_valid = 1'b0;
      start_cycle;
      @(negedge clk);
      if (rsp0_valid !== 1'b1) begin $display("FAIL zero_rsp0 got=%b exp=1", rsp0_valid); n_err++; end
      n_cmp++;
      if (rsp_data !== 32'd0) begin $display("FAIL zero_data got=%0h exp=0", rsp_data); n_err++; end
      n_cmp++;
      if (rsp_zero !== 1'b1) begin $display("FAIL zero_flag got=%b exp=1", rsp_zero); n_err++; end
      n_cmp++;
      $display("test_zero_flag done: compared=%0d mismatched=%0d", n_cmp, n_err);
      do_reset;
   endtask

   task automatic test_reset_mid_op;
      req0_valid = 1'b1; req0_aluop = 3'b111; req0_funct = 6'b100000; req0_a = 32'd1; req0_b = 32'd2;
      @(negedge clk);
      if (req0_ready !== 1'b1) begin $display("FAIL midrst_ready0 got=%b exp=1", req0_ready); n_err++; end
      n_cmp++;
      start_cycle;
      // EXEC cycle: reset asserted, client 1 starts requesting
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_aluop = 3'b001; req1_funct = 6'b000000; req1_a = 32'h0F; req1_b = 32'hF0;
      reset = 1'b1;
      @(negedge clk);
      if (busy !== 1'b1 || req1_ready !== 1'b0) begin $display("FAIL midrst_exec got busy=%b rdy1=%b exp busy=1 rdy1=0", busy, req1_ready); n_err++; end
      n_cmp++;
      start_cycle;
      reset = 1'b0;
      @(negedge clk);
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin $display("FAIL midrst_no_rsp got=%b exp=00", {rsp0_valid, rsp1_valid}); n_err++; end
      n_cmp++;
      if (busy !== 1'b0) begin $display("FAIL midrst_idle got busy=%b exp=0", busy); n_err++; end
      n_cmp++;
      if (rsp_data !== 32'd0) begin $display("FAIL midrst_data got=%0h exp=0", rsp_data); n_err++; end
      n_cmp++;
      if (req1_ready !== 1'b1) begin $display("FAIL midrst_ready1 got=%b exp=1", req1_ready); n_err++; end
      n_cmp++;
      start_cycle;
      req1_valid = 1'b0;
      start_cycle;
      @(negedge clk);
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin $display("FAIL midrst_rsp1 got=%b%b exp=01", rsp0_valid, rsp1_valid); n_err++; end
      n_cmp++;
      if (rsp_data !== 32'hFF) begin $display("FAIL midrst_rsp_data got=%0h exp=ff", rsp_data); n_err++; end
      n_cmp++;
      $display("test_reset_mid_op done: compared=%0d mismatched=%0d", n_cmp, n_err);
   endtask

   initial begin
      test_reset;
      test_single_add;
      test_contention;
      test_back_to_back;
      test_zero_flag;
      test_reset_mid_op;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the single shared ALU datapath (ALUControl decoder plus ALU). It accepts operation requests (ALUOp, function field, two operands) from two independent clients. It grants them round-robin and drives the shared ALUControl/ALU inputs for exactly one cycle per operation. It registers the ALU result and zero flag and returns them to the granted client with a one-cycle response strobe.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  client 0 request
- req0_ready  out  1  client 0 accept strobe
- req0_aluop  in  3  ALUOp for client 0
- req0_funct  in  6  function field for client 0
- req0_a, req0_b  in  DATA_WIDTH  operands for client 0
- req1_valid, req1_ready, req1_aluop, req1_funct, req1_a, req1_b  same as client 0
- alu_op  out  3  to ALUControl ALUOp
- alu_funct  out  6  to ALUControl ALUFunction
- alu_a, alu_b  out  DATA_WIDTH  to ALU operands
- alu_result  in  DATA_WIDTH  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag
- rsp0_valid, rsp1_valid  out  1  one-cycle response strobe per client
- rsp_data  out  DATA_WIDTH  registered result
- rsp_zero  out  1  registered zero flag
- busy  out  1  high in EXEC or RESP
- last_grant  out  1  index of most recently accepted client

## Operation
- FSM states: IDLE, EXEC, RESP.
- Accept window: IDLE and RESP.
  - In the window, choose the winner:
    - Only one valid: that client wins.
    - Both valid: the client != last_grant wins.
  - Winner's reqN_ready is driven combinationally high in that cycle. Loser's ready stays low.
  - On accept: latch aluop/funct/a/b into the issue registers, set last_grant = winner, go to EXEC.
  - IDLE, no valid: stay IDLE.
  - RESP, no valid: go to IDLE.
- EXEC:
  - alu_op/alu_funct driven from the issue registers.
  - alu_a/alu_b driven from the latched operands.
  - At the clock edge, capture alu_result to rsp_data and alu_zero to rsp_zero. Go to RESP.
  - No accept in EXEC; both readies low.
- RESP:
  - rsp{winner}_valid high for exactly this cycle. The other rsp valid stays low.
  - rsp_data/rsp_zero hold until the next EXEC capture.
- Outside EXEC, alu_op = 3'b000 and alu_funct = 6'b000000. alu_a/alu_b hold the last latched values.
- Client rules:
  - Once valid is raised, valid and payload stay stable until ready.
  - The arbiter never drops or reorders an accepted request.
- Reset (sync, any state):
  - Next state IDLE; any in-flight operation is discarded with no response.
  - All outputs 0, except last_grant = 1 so client 0 wins the first tie.
  - Readies are low during the reset cycle.

## Timing
- Accept at edge T (ready & valid in cycle T). EXEC in cycle T+1. rsp valid in cycle T+2.
- Latency is 2 cycles from accept to response.
- Peak throughput is 1 operation per 2 cycles, with accepts overlapping RESP.
- ALU path must settle within one clk period (alu_a/b/op → alu_result).
- Simultaneous events:
  - In RESP: the response for op N and the accept of op N+1 occur in the same cycle.
  - The winner is computed using last_grant already updated by op N.
- Reset dominates all other inputs in the same cycle.

## Test plan
- Reset: hold reset 2 cycles with both valids high → readies 0, rsp valids 0, busy 0, alu_op 0, last_grant 1. First cycle after release: req0_ready = 1.
- Single add: req0 aluop 3'b111, funct 6'b100000, a=5, b=7, ALU reference model attached.
  - Cycle T: req0_ready.
  - Cycle T+1: alu_op = 3'b111, alu_funct = 6'b100000.
  - Cycle T+2: rsp0_valid, rsp_data = 12, rsp_zero = 0.
- Contention: both valid continuously with distinct ops → grants 0,1,0,1. Accepts at T, T+2, T+4, T+6. Each rsp strobe matches its client's op. No rsp valid while no accept has occurred.
- Back-to-back single client: req1 only, ORI aluop 3'b001, a=0x0F, b=0xF0, four ops → accepts every 2 cycles, each rsp_data = 0xFF, rsp0_valid never high.
- Zero flag: req0 AND (3'b111/6'b100100), a=0xF0, b=0x0F → rsp_data = 0, rsp_zero = 1.
- Reset mid-operation: assert reset in the EXEC cycle → no rsp valid the following cycle, state IDLE. A pending req1 is accepted in the first cycle after release.
